// File: rtl/button_debouncer.sv
// button_debouncer
//   Debounces and synchronizes raw push-button lines ahead of the Nios II
//   button PIO. Each channel passes through a two-flop synchronizer and is
//   normalized to active-high. A new level is accepted only after it has been
//   seen for DEBOUNCE_CYCLES consecutive samples. Channels are independent.
//
// Parameters
//   WIDTH           number of button channels
//   DEBOUNCE_CYCLES consecutive stable samples needed to accept a change (>= 1)
//   CNT_W           counter width, 2**CNT_W >= DEBOUNCE_CYCLES
//   ACTIVE_LOW      1: raw line reads 0 when the button is pressed
//
// Ports
//   clk           system clock
//   reset_n       synchronous active-low reset
//   raw_in        asynchronous button pins
//   db_out        debounced level, 1 = pressed (feeds PIO in_port)
//   press_pulse   one-cycle strobe on an accepted 0->1 of db_out
//   release_pulse one-cycle strobe on an accepted 1->0 of db_out
//   changed       OR of all press/release strobes
module button_debouncer #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 19,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] db_out,
  output logic [WIDTH-1:0] press_pulse,
  output logic [WIDTH-1:0] release_pulse,
  output logic             changed
);

  // Synchronizers reset to the idle (released) raw level so that leaving
  // reset never looks like a press.
  localparam logic [WIDTH-1:0] IDLE_LEVEL = {WIDTH{ACTIVE_LOW}};
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1_q;
  logic [WIDTH-1:0] sync2_q;
  logic [WIDTH-1:0] norm;

  logic [WIDTH-1:0] stable_q, stable_d;
  logic [WIDTH-1:0] press_q,  press_d;
  logic [WIDTH-1:0] rel_q,    rel_d;
  logic             changed_q, changed_d;
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  always_comb begin
    norm = ACTIVE_LOW ? ~sync2_q : sync2_q;
  end

  // Per-channel acceptance. Any sample that agrees with the stable level
  // clears the count, so only an unbroken run of DEBOUNCE_CYCLES differing
  // samples is accepted; the count is held at or below CNT_LAST.
  always_comb begin
    stable_d = stable_q;
    press_d  = '0;
    rel_d    = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (norm[i] != stable_q[i]) begin
        if (cnt_q[i] == CNT_LAST) begin
          stable_d[i] = norm[i];
          press_d[i]  = norm[i];
          rel_d[i]    = ~norm[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
    changed_d = |{press_d, rel_d};
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q   <= IDLE_LEVEL;
      sync2_q   <= IDLE_LEVEL;
      stable_q  <= '0;
      press_q   <= '0;
      rel_q     <= '0;
      changed_q <= 1'b0;
      cnt_q     <= '{default: '0};
    end else begin
      sync1_q   <= raw_in;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      press_q   <= press_d;
      rel_q     <= rel_d;
      changed_q <= changed_d;
      cnt_q     <= cnt_d;
    end
  end

  assign db_out        = stable_q;
  assign press_pulse   = press_q;
  assign release_pulse = rel_q;
  assign changed       = changed_q;

endmodule

// File: tb/tb_button_debouncer.sv
module tb_button_debouncer;

  typedef struct {
    int         cyc;
    logic [3:0] db;
    logic [3:0] pr;
    logic [3:0] rl;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] raw_a = 4'b1111;
  logic [3:0] raw_b = 4'b0000;
  logic [3:0] db_a, pr_a, rl_a, db_b, pr_b, rl_b;
  logic       ch_a, ch_b;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  logic rst_edge = 1'b0;
  logic [3:0] exp_a = '0;
  logic [3:0] exp_b = '0;
  ev_t  qa[$];
  ev_t  qb[$];

  button_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .CNT_W(4), .ACTIVE_LOW(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_a), .db_out(db_a),
    .press_pulse(pr_a), .release_pulse(rl_a), .changed(ch_a));

  button_debouncer #(.WIDTH(4), .DEBOUNCE_CYCLES(1), .CNT_W(1), .ACTIVE_LOW(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .raw_in(raw_b), .db_out(db_b),
    .press_pulse(pr_b), .release_pulse(rl_b), .changed(ch_b));

  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= !reset_n;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor for the active-low, 8-cycle instance.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      if (rst_edge) exp_a = '0;
      if (ch_a) begin
        if (qa.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL A unexpected strobe at cycle %0d: press %b release %b", cyc, pr_a, rl_a);
        end else begin
          e = qa.pop_front();
          chk("A strobe cycle", cyc, e.cyc);
          chk("A db_out", {28'd0, db_a}, {28'd0, e.db});
          chk("A press", {28'd0, pr_a}, {28'd0, e.pr});
          chk("A release", {28'd0, rl_a}, {28'd0, e.rl});
          exp_a = e.db;
        end
      end else begin
        chk("A idle strobes", {24'd0, pr_a, rl_a}, 32'd0);
        if (qa.size() != 0 && qa[0].cyc < cyc) begin
          e = qa.pop_front();
          n_chk++; n_fail++;
          $display("FAIL A missing strobe, expected at cycle %0d", e.cyc);
        end
      end
      chk("A level", {28'd0, db_a}, {28'd0, exp_a});
    end
  end

  // Monitor for the active-high, 1-cycle instance.
  always @(negedge clk) begin
    if (mon_en) begin
      ev_t e;
      if (rst_edge) exp_b = '0;
      if (ch_b) begin
        if (qb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL B unexpected strobe at cycle %0d: press %b release %b", cyc, pr_b, rl_b);
        end else begin
          e = qb.pop_front();
          chk("B strobe cycle", cyc, e.cyc);
          chk("B db_out", {28'd0, db_b}, {28'd0, e.db});
          chk("B press", {28'd0, pr_b}, {28'd0, e.pr});
          chk("B release", {28'd0, rl_b}, {28'd0, e.rl});
          exp_b = e.db;
        end
      end else begin
        chk("B idle strobes", {24'd0, pr_b, rl_b}, 32'd0);
        if (qb.size() != 0 && qb[0].cyc < cyc) begin
          e = qb.pop_front();
          n_chk++; n_fail++;
          $display("FAIL B missing strobe, expected at cycle %0d", e.cyc);
        end
      end
      chk("B level", {28'd0, db_b}, {28'd0, exp_b});
    end
  end

  // Inputs change just after a falling edge at cycle n, so the first sampling
  // edge is n+1 and an 8-cycle debounce lands on edge n+10 (n+3 for 1 cycle).
  task automatic push_a(input int lat, input logic [3:0] db, input logic [3:0] pr, input logic [3:0] rl);
    qa.push_back('{cyc: cyc + lat, db: db, pr: pr, rl: rl});
  endtask

  task automatic push_b(input int lat, input logic [3:0] db, input logic [3:0] pr, input logic [3:0] rl);
    qb.push_back('{cyc: cyc + lat, db: db, pr: pr, rl: rl});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // 1. Reset with buttons idle, then 20 quiet cycles.
    reset_n = 1'b0;
    raw_a   = 4'b1111;
    raw_b   = 4'b0000;
    step(3);
    mon_en  = 1'b1;
    reset_n = 1'b1;
    step(20);

    // 2. Clean press and release on channel 0.
    raw_a = 4'b1110; push_a(10, 4'b0001, 4'b0001, 4'b0000);
    step(20);
    raw_a = 4'b1111; push_a(10, 4'b0000, 4'b0000, 4'b0001);
    step(20);

    // 3. Bounce on channel 1: 7-sample lows never accepted, then a held low.
    for (int k = 0; k < 5; k++) begin
      raw_a = 4'b1101; step(7);
      raw_a = 4'b1111; step(1);
    end
    raw_a = 4'b1101; push_a(10, 4'b0010, 4'b0010, 4'b0000);
    step(20);
    raw_a = 4'b1111; push_a(10, 4'b0000, 4'b0000, 4'b0010);
    step(20);

    // 4. All channels together.
    raw_a = 4'b0000; push_a(10, 4'b1111, 4'b1111, 4'b0000);
    step(20);
    raw_a = 4'b1111; push_a(10, 4'b0000, 4'b0000, 4'b1111);
    step(20);

    // 5. Reset pulse at count 5 on channel 2; first post-reset sampling
    //    edge is n+8, so acceptance lands on edge n+17.
    raw_a = 4'b1011; push_a(17, 4'b0100, 4'b0100, 4'b0000);
    step(6);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(20);
    raw_a = 4'b1111; push_a(10, 4'b0000, 4'b0000, 4'b0100);
    step(20);

    // 6. Active-high, single-sample instance on channel 3, then back-to-back.
    raw_b = 4'b1000; push_b(3, 4'b1000, 4'b1000, 4'b0000);
    step(5);
    raw_b = 4'b0000; push_b(3, 4'b0000, 4'b0000, 4'b1000);
    step(1);
    raw_b = 4'b1000; push_b(3, 4'b1000, 4'b1000, 4'b0000);
    step(1);
    raw_b = 4'b0000; push_b(3, 4'b0000, 4'b0000, 4'b1000);
    step(10);

    mon_en = 1'b0;
    chk("A queue drained", qa.size(), 32'd0);
    chk("B queue drained", qb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
